seq_adder: RTL and testbench
============================

# seq_adder

Parametrised multi-cycle adder/subtractor for the datapath. It processes a WIDTH-bit operation CHUNK bits per clock, using a start/busy/done handshake, and produces carry, signed-overflow and zero flags. It sits beside the combinational adder. The multi-cycle control uses it for wide or area-constrained arithmetic, where a full-width single-cycle carry chain is not wanted.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- CHUNK, 2: bits added per cycle; must divide WIDTH exactly. N = WIDTH/CHUNK is the iteration count.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result and flags just updated
- y  out  WIDTH  result; holds until the next completion
- cout  out  1  carry out of the MSB (for sub: 1 = no borrow, i.e. a ≥ b unsigned)
- ovf  out  1  two's-complement overflow
- zero  out  1  y == 0

One clock; reset is asynchronous and active-high.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, chunk index k = 0..N−1.
- Reset, asynchronous, takes effect immediately:
  - state returns to IDLE.
  - busy, done, y, cout, ovf and zero all go to 0.
  - internal operand, partial-sum and carry registers clear.
- Accept: at a rising edge where busy=0 and start=1:
  - latch a into opA.
  - latch b ^ {WIDTH{sub}} into opB.
  - set carry to sub.
  - set k = 0 and enter RUN.
  - start is ignored while busy=1. A request is not queued.
- RUN, each edge:
  - chunk sum = opA[k] + opB[k] + carry, computed (CHUNK+1) bits wide.
  - low CHUNK bits go to partial[k]. The MSB becomes the new carry.
  - for the final chunk, also keep the carry into the MSB, for overflow.
  - k increments.
- Completion, on the edge that processes k = N−1:
  - y is set to the full partial result.
  - cout is the final carry.
  - ovf is the carry into the MSB XOR the carry out of the MSB.
  - zero is (result == 0).
  - done=1 for exactly that one cycle. busy=0 and state returns to IDLE.
- Outputs y, cout, ovf and zero change only at completion or reset. They never expose partial results.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- Back-to-back: start=1 during the done cycle is accepted, because busy=0. The new operation completes N cycles later. The previous y is held until then.

## Timing
- Latency: the accept edge is E0 and completion is at edge EN. done is high during the cycle after EN, so results arrive N cycles after acceptance.
- busy is high from E0 to EN, exactly N cycles.
- Throughput: one operation per N cycles, with no dead cycle between operations.
- N=1 (CHUNK=WIDTH): busy is high for 1 cycle, then done.
- a, b and sub may change freely after the accept edge.
- Reset asserted during RUN aborts the operation. done does not pulse, and the outputs read 0 until the next completion.
- Simultaneous reset and start: reset wins and start is dropped.

## Test plan
Configuration for all tests: WIDTH=8, CHUNK=2, N=4, unless noted.

1. Reset: assert reset -> busy=0, done=0, y=8'h00, cout=ovf=zero=0. Hold start=0 for 10 cycles -> the outputs stay unchanged.
2. Signed overflow on add: a=8'h7F, b=8'h01, sub=0, start for 1 cycle -> busy high for 4 cycles, then done pulse; y=8'h80, cout=0, ovf=1, zero=0. Also a=8'hFF, b=8'h01 -> y=8'h00, cout=1, ovf=0, zero=1.
3. Subtract:
   - a=8'h05, b=8'h07, sub=1 -> y=8'hFE, cout=0, ovf=0.
   - a=8'h80, b=8'h01, sub=1 -> y=8'h7F, cout=1, ovf=1.
   - a=8'h33, b=8'h33, sub=1 -> y=8'h00, cout=1, zero=1.
4. Handshake:
   - Start a=8'h10, b=8'h20. Pulse start with a=8'hAA during the 2nd busy cycle -> the second request is ignored; y=8'h30 after 4 cycles, with a single done pulse.
   - Raise start during the done cycle -> it is accepted. The next done comes exactly 4 cycles later, and y holds 8'h30 until then.
5. Abort: start a=8'hF0, b=8'h0F. Assert reset in the 3rd busy cycle -> busy, y and the flags drop to 0 asynchronously, and no done pulse follows. After release, a new start completes normally.
6. Parameter sweep: WIDTH=16 with CHUNK=1, 4, 16 (N=16, 4, 1). Run 1000 random a/b/sub per configuration against a reference model -> y, cout, ovf and zero all match. busy high exactly N cycles per operation.

Source files
------------

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor.
// A WIDTH-bit add or subtract is processed CHUNK bits per clock over
// N = WIDTH/CHUNK cycles. The block uses a start/busy/done handshake and
// produces carry, signed-overflow and zero flags.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per cycle, must divide WIDTH
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  request, sampled only while busy = 0
//   sub    0: a + b, 1: a - b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   operation in progress (N cycles)
//   done   one-cycle pulse after the result and flags update
//   y      result, held until the next completion
//   cout   carry out of the MSB (for sub: 1 = no borrow)
//   ovf    two's-complement overflow
//   zero   y == 0
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] partial;
  logic             carry;
  logic [KW-1:0]    k;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             carry_msb;
  logic             last;
  logic [WIDTH-1:0] result;

  // Chunk adder for the current index plus the full result as it would look
  // once this chunk is merged in (used only on the final chunk).
  always_comb begin
    base      = int'(k) * CHUNK;
    a_chunk   = opa[base +: CHUNK];
    b_chunk   = opb[base +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit of the chunk
    // is recovered without a separate narrower adder.
    carry_msb = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    last      = (k == KW'(N - 1));
    result    = partial;
    result[base +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Control FSM and datapath registers; outputs only move at completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opa     <= {WIDTH{1'b0}};
      opb     <= {WIDTH{1'b0}};
      partial <= {WIDTH{1'b0}};
      carry   <= 1'b0;
      k       <= {KW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa     <= a;
            // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
            opb     <= b ^ {WIDTH{sub}};
            carry   <= sub;
            partial <= {WIDTH{1'b0}};
            k       <= {KW{1'b0}};
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          partial[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry                  <= chunk_sum[CHUNK];
          if (last) begin
            y     <= result;
            cout  <= chunk_sum[CHUNK];
            ovf   <= carry_msb ^ chunk_sum[CHUNK];
            zero  <= (result == {WIDTH{1'b0}});
            done  <= 1'b1;
            busy  <= 1'b0;
            k     <= {KW{1'b0}};
            state <= IDLE;
          end else begin
            k    <= k + KW'(1);
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: self-checking bench for seq_adder.
// Four instances: 8/2 (N=4) for the directed tests, and 16/1, 16/4, 16/16
// for the random parameter sweep. Expected results come from a
// width-generic reference model and go through a scoreboard queue.
module tb_seq_adder;

  typedef struct packed {
    logic [15:0] y;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        start0, start1, start2, start3;
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic        cout0, cout1, cout2, cout3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic        zero0, zero1, zero2, zero3;
  logic [7:0]  y0;
  logic [15:0] y1, y2, y3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .busy(busy0), .done(done0), .y(y0), .cout(cout0), .ovf(ovf0), .zero(zero0));
  seq_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .y(y1), .cout(cout1), .ovf(ovf1), .zero(zero1));
  seq_adder #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(sub), .a(a), .b(b),
    .busy(busy2), .done(done2), .y(y2), .cout(cout2), .ovf(ovf2), .zero(zero2));
  seq_adder #(.WIDTH(16), .CHUNK(16)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .sub(sub), .a(a), .b(b),
    .busy(busy3), .done(done3), .y(y3), .cout(cout3), .ovf(ovf3), .zero(zero3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(input int d);
    return (d == 0) ? 8 : 16;
  endfunction

  function automatic int n_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      2:       return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return done0;
      1:       return done1;
      2:       return done2;
      default: return done3;
    endcase
  endfunction

  function automatic exp_t get_out(input int d);
    exp_t o;
    case (d)
      0:       o = '{y: {8'h00, y0}, c: cout0, v: ovf0, z: zero0};
      1:       o = '{y: y1, c: cout1, v: ovf1, z: zero1};
      2:       o = '{y: y2, c: cout2, v: ovf2, z: zero2};
      default: o = '{y: y3, c: cout3, v: ovf3, z: zero3};
    endcase
    return o;
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      2:       start2 = v;
      default: start3 = v;
    endcase
  endtask

  // Reference: full-width add of a and (sub ? ~b : b) plus sub, truncated.
  function automatic exp_t model(input int w, input logic [15:0] aa,
                                 input logic [15:0] bb, input logic s);
    exp_t        e;
    logic [16:0] mask;
    logic [16:0] sum;
    logic [15:0] am;
    logic [15:0] bx;
    mask = (17'd1 << w) - 17'd1;
    am   = aa & mask[15:0];
    bx   = (s ? ~bb : bb) & mask[15:0];
    sum  = {1'b0, am} + {1'b0, bx} + {16'd0, s};
    e.y  = sum[15:0] & mask[15:0];
    e.c  = sum[w];
    e.v  = (am[w-1] == bx[w-1]) && (e.y[w-1] != am[w-1]);
    e.z  = (e.y == 16'h0000);
    return e;
  endfunction

  // Pops one expectation and compares it with the outputs of instance d.
  task automatic compare_result(input int d, input string tag);
    exp_t e;
    exp_t o;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: done with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      o = get_out(d);
      checks++;
      if (o.y !== e.y) begin
        errors++;
        $display("FAIL %s y: got %h expected %h", tag, o.y, e.y);
      end
      checks++;
      if (o.c !== e.c) begin
        errors++;
        $display("FAIL %s cout: got %b expected %b", tag, o.c, e.c);
      end
      checks++;
      if (o.v !== e.v) begin
        errors++;
        $display("FAIL %s ovf: got %b expected %b", tag, o.v, e.v);
      end
      checks++;
      if (o.z !== e.z) begin
        errors++;
        $display("FAIL %s zero: got %b expected %b", tag, o.z, e.z);
      end
    end
  endtask

  // Called at a negedge; drives one request, waits for done, checks results
  // and that busy stayed high for exactly N cycles. Returns in the done cycle.
  task automatic run_op(input int d, input logic [15:0] aa, input logic [15:0] bb,
                        input logic s, input string tag);
    int cnt;
    bit seen;
    a = aa;
    b = bb;
    sub = s;
    set_start(d, 1'b1);
    sb.push_back(model(width_of(d), aa, bb, s));
    @(negedge clk);
    set_start(d, 1'b0);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (get_done(d)) begin
        seen = 1'b1;
        break;
      end
      if (get_busy(d)) cnt++;
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done expected done within 40 cycles", tag);
      void'(sb.pop_front());
    end else begin
      checks++;
      if (cnt != n_of(d)) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cnt, n_of(d));
      end
      compare_result(d, tag);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy0); end
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done0); end
    checks++;
    if (y0 !== 8'h00) begin errors++; $display("FAIL reset y: got %h expected 00", y0); end
    checks++;
    if ({cout0, ovf0, zero0} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 000", {cout0, ovf0, zero0});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy0, done0, y0, cout0, ovf0, zero0} !== 13'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h expected 0", i,
                 {busy0, done0, y0, cout0, ovf0, zero0});
      end
    end
  endtask

  task automatic test_add_overflow;
    run_op(0, 16'h007F, 16'h0001, 1'b0, "add_7f_01");
    run_op(0, 16'h00FF, 16'h0001, 1'b0, "add_ff_01");
  endtask

  task automatic test_subtract;
    run_op(0, 16'h0005, 16'h0007, 1'b1, "sub_05_07");
    run_op(0, 16'h0080, 16'h0001, 1'b1, "sub_80_01");
    run_op(0, 16'h0033, 16'h0033, 1'b1, "sub_33_33");
  endtask

  task automatic test_handshake;
    bit seen;
    a = 16'h0010;
    b = 16'h0020;
    sub = 1'b0;
    start0 = 1'b1;
    sb.push_back(model(8, 16'h0010, 16'h0020, 1'b0));
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    // Second busy cycle: this request must be dropped.
    a = 16'h00AA;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hs_first timeout: got no done expected done");
    end
    compare_result(0, "hs_first");
    // Done cycle: new request is accepted back-to-back.
    a = 16'h0001;
    b = 16'h0002;
    start0 = 1'b1;
    sb.push_back(model(8, 16'h0001, 16'h0002, 1'b0));
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy0, done0, y0} !== {1'b1, 1'b0, 8'h30}) begin
        errors++;
        $display("FAIL hs_hold cycle %0d: got busy=%b done=%b y=%h expected busy=1 done=0 y=30",
                 i, busy0, done0, y0);
      end
      @(negedge clk);
    end
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL hs_second done: got %b expected 1", done0);
    end
    compare_result(0, "hs_second");
  endtask

  task automatic test_abort;
    int dones;
    a = 16'h00F0;
    b = 16'h000F;
    sub = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL abort busy: got %b expected 0", busy0); end
    checks++;
    if (y0 !== 8'h00) begin errors++; $display("FAIL abort y: got %h expected 00", y0); end
    checks++;
    if ({done0, cout0, ovf0, zero0} !== 4'b0000) begin
      errors++;
      $display("FAIL abort flags: got %b expected 0000", {done0, cout0, ovf0, zero0});
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort no_done: got %0d done pulses expected 0", dones);
    end
    run_op(0, 16'h0012, 16'h0034, 1'b0, "after_abort");
  endtask

  task automatic test_sweep;
    logic [15:0] aa;
    logic [15:0] bb;
    logic        s;
    for (int d = 1; d < 4; d++) begin
      for (int i = 0; i < 1000; i++) begin
        aa = 16'($urandom);
        bb = 16'($urandom);
        s  = 1'($urandom_range(0, 1));
        if (i % 10 == 0) aa = 16'h8000;
        if (i % 10 == 1) aa = 16'h7FFF;
        if (i % 10 == 2) bb = aa;
        run_op(d, aa, bb, s, "sweep");
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    sub    = 1'b0;
    a      = 16'h0000;
    b      = 16'h0000;
    test_reset();
    test_add_overflow();
    test_subtract();
    test_handshake();
    test_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
